// File: rtl/qam16_pkg.sv
// Shared constants and Gray level helper for the 16-QAM PRBS source.
// Gray pairs map 00,01,11,10 to the levels -3,-1,+1,+3.
package qam16_pkg;

  localparam logic signed [3:0] LVL_M3 = -4'sd3;
  localparam logic signed [3:0] LVL_M1 = -4'sd1;
  localparam logic signed [3:0] LVL_P1 = 4'sd1;
  localparam logic signed [3:0] LVL_P3 = 4'sd3;

  // x^4+x^3+1: feedback is q[3]^q[2]
  localparam logic [3:0] LFSR_TAPS    = 4'b1100;
  localparam logic [3:0] DEFAULT_SEED = 4'h1;

  function automatic logic signed [3:0] gray2lvl(
    input logic [1:0] g
  );
    logic signed [3:0] lvl;
    unique case (g)
      2'b00: lvl = LVL_M3;
      2'b01: lvl = LVL_M1;
      2'b11: lvl = LVL_P1;
      2'b10: lvl = LVL_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_mapper.sv
// Combinational Gray-coded 16-QAM mapper.
// data_i[3:2] selects the I level, data_i[1:0] the Q level.
module qam16_mapper
  import qam16_pkg::*;
(
  input  logic [3:0]        data_i,
  output logic signed [3:0] i_lvl_o,
  output logic signed [3:0] q_lvl_o
);

  assign i_lvl_o = gray2lvl(data_i[3:2]);
  assign q_lvl_o = gray2lvl(data_i[1:0]);

endmodule

// File: rtl/qam16_prbs_src.sv
// 4-bit PRBS (x^4+x^3+1) driving a Gray-coded 16-QAM mapper.
// SYMMAP_OUT_REG_EN registers the I/Q levels for one extra cycle.
module qam16_prbs_src
  import qam16_pkg::*;
#(
  parameter logic [3:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  output logic [3:0]        q,
  output logic signed [3:0] i_out,
  output logic signed [3:0] q_out
);

  // An all-zero seed would lock the LFSR, so it falls back to 1
  localparam logic [3:0] SEED_EFF =
    (SEED == 4'h0) ? 4'h1 : SEED;

  logic [3:0]        lfsr_q;
  logic [3:0]        lfsr_d;
  logic signed [3:0] map_i;
  logic signed [3:0] map_q;

  always_comb begin
    lfsr_d = {lfsr_q[2:0], ^(lfsr_q & LFSR_TAPS)};
    if (lfsr_q == 4'h0) lfsr_d = 4'h1;
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED_EFF;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

  qam16_mapper u_map (
    .data_i  (lfsr_q),
    .i_lvl_o (map_i),
    .q_lvl_o (map_q)
  );

`ifdef SYMMAP_OUT_REG_EN
  logic signed [3:0] iout_q;
  logic signed [3:0] qout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      iout_q <= 4'sd0;
      qout_q <= 4'sd0;
    end else begin
      iout_q <= map_i;
      qout_q <= map_q;
    end
  end

  assign i_out = iout_q;
  assign q_out = qout_q;
`else
  assign i_out = map_i;
  assign q_out = map_q;
`endif

endmodule

// File: tb/tb_qam16_prbs_src.sv
// Randomized self-checking bench for qam16_prbs_src.
// A second instance uses SEED=0 and must behave like the default.
module tb_qam16_prbs_src;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        q, q0;
  logic signed [3:0] i_out, q_out, i0, qo0;

  int errors = 0;
  int checks = 0;

  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                           4'h6, 4'hD, 4'hA, 4'h5, 4'hB,
                           4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  int         idx = 0;
  logic [3:0] exp_q;
  logic [3:0] exp_i;
  logic [3:0] exp_qo;

  always #5 clk = ~clk;

  qam16_prbs_src dut (
    .clk   (clk),
    .reset (reset),
    .q     (q),
    .i_out (i_out),
    .q_out (q_out)
  );

  qam16_prbs_src #(.SEED(4'h0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .q     (q0),
    .i_out (i0),
    .q_out (qo0)
  );

  // Gray index -> amplitude: levels are 2*k-3 for k = 0..3
  function automatic logic [3:0] lvl(input logic [1:0] g);
    int k;
    int v;
    k = {30'd0, g[1], g[1] ^ g[0]};
    v = 2 * k - 3;
    return v[3:0];
  endfunction

  task automatic check(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)",
               tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // One clock with the current reset value, then model update and checks
  task automatic step();
    logic [3:0] prev;
    prev = seq[idx];
    @(posedge clk);
`ifdef SYMMAP_OUT_REG_EN
    if (reset) begin
      exp_i  = 4'h0;
      exp_qo = 4'h0;
    end else begin
      exp_i  = lvl(prev[3:2]);
      exp_qo = lvl(prev[1:0]);
    end
`endif
    if (reset) idx = 0;
    else       idx = (idx + 1) % 15;
    exp_q = seq[idx];
`ifndef SYMMAP_OUT_REG_EN
    exp_i  = lvl(exp_q[3:2]);
    exp_qo = lvl(exp_q[1:0]);
`endif
    #1;
    check("q",      q,     exp_q);
    check("i_out",  i_out, exp_i);
    check("q_out",  q_out, exp_qo);
    check("q_s0",   q0,    exp_q);
    check("i_s0",   i0,    exp_i);
    check("qo_s0",  qo0,   exp_qo);
  endtask

  initial begin
    reset = 1'b1;
    step();
    check("rst_q", q, 4'h1);
    reset = 1'b0;

    for (int k = 1; k <= 15; k++) step();
    check("wrap_q", q, 4'h1);

    // Directed mid-run reset when q reaches 0xB
    for (int k = 0; k < 9; k++) step();
    check("at_B", q, 4'hB);
    reset = 1'b1;
    step();
    check("mid_rst", q, 4'h1);
    reset = 1'b0;
    step();
    check("restart2", q, 4'h2);
    step();
    check("restart4", q, 4'h4);
    step();
    check("restart9", q, 4'h9);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
